// File: rtl/mesm6_io_pkg.sv
// Shared types and bus widths for the MESM-6 peripheral register bus arbiter.
package mesm6_io_pkg;

  localparam int IO_ADDR_W = 15;
  localparam int IO_DATA_W = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } io_state_t;

endpackage

// File: rtl/mesm6_rr_pick.sv
// Combinational round-robin picker: first pending index at or after ptr, wrapping mod NREQ.
module mesm6_rr_pick #(
  parameter int NREQ  = 2,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  pending,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] winner
);

  localparam logic [PTR_W:0] NREQ_V = (PTR_W + 1)'(NREQ);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [PTR_W-1:0]  off;
  logic [PTR_W:0]    sum;

  // rot[k] is the pending bit of requester (ptr + k) mod NREQ.
  assign dbl = {pending, pending} >> ptr;
  assign rot = dbl[NREQ-1:0];

  always_comb begin
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = PTR_W'(k);
      end
    end
  end

  assign valid  = |rot;
  assign sum    = {1'b0, ptr} + {1'b0, off};
  assign winner = (sum >= NREQ_V) ? PTR_W'(sum - NREQ_V) : PTR_W'(sum);

endmodule

// File: rtl/mesm6_io_arbiter.sv
// Round-robin arbiter sharing one MESM-6 peripheral register bus between NREQ requesters,
// with a one-cycle device strobe and a timeout error completion.
module mesm6_io_arbiter
  import mesm6_io_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_read,
  input  logic [NREQ-1:0]           req_write,
  input  logic [NREQ*IO_ADDR_W-1:0] req_addr,
  input  logic [NREQ*IO_DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]           req_done,
  output logic                      req_err,
  output logic [IO_DATA_W-1:0]      req_rdata,
  output logic [IO_ADDR_W-1:0]      io_addr,
  output logic                      io_read,
  output logic                      io_write,
  output logic [IO_DATA_W-1:0]      io_wdata,
  input  logic [IO_DATA_W-1:0]      io_rdata,
  input  logic                      io_done,
  output logic                      busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NREQ - 1);

  io_state_t            state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     grant_q, grant_d;
  logic                 write_q, write_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IO_ADDR_W-1:0] addr_q, addr_d;
  logic [IO_DATA_W-1:0] wdata_q, wdata_d;
  logic [IO_DATA_W-1:0] rdata_q, rdata_d;

  logic [NREQ-1:0]      pending;
  logic [IO_ADDR_W-1:0] addr_arr  [NREQ];
  logic [IO_DATA_W-1:0] wdata_arr [NREQ];
  logic                 pick_valid;
  logic [PTR_W-1:0]     pick_winner;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign pending[gi]   = req_read[gi] | req_write[gi];
      assign addr_arr[gi]  = req_addr[gi*IO_ADDR_W +: IO_ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*IO_DATA_W +: IO_DATA_W];
    end
  endgenerate

  mesm6_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .pending (pending),
    .ptr     (ptr_q),
    .valid   (pick_valid),
    .winner  (pick_winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      write_q <= write_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    write_d = write_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_winner;
          addr_d  = addr_arr[pick_winner];
          wdata_d = wdata_arr[pick_winner];
          // A simultaneous read+write from one requester is issued as a write.
          write_d = req_write[pick_winner];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (io_done) begin
          rdata_d = write_q ? '0 : io_rdata;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LIMIT) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + PTR_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_done  = '0;
    req_err   = 1'b0;
    req_rdata = '0;
    io_read   = 1'b0;
    io_write  = 1'b0;
    io_addr   = addr_q;
    io_wdata  = wdata_q;
    busy      = (state_q != IDLE);
    if (state_q == ISSUE) begin
      io_read  = ~write_q;
      io_write = write_q;
    end
    if (state_q == DONE) begin
      req_done[grant_q] = 1'b1;
      req_err           = err_q;
      req_rdata         = rdata_q;
    end
  end

endmodule

// File: tb/tb_mesm6_io_arbiter.sv
// Directed self-checking bench for mesm6_io_arbiter (NREQ=2, TIMEOUT=4).
module tb_mesm6_io_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 4;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_read;
  logic [NREQ-1:0]   req_write;
  logic [NREQ*15-1:0] req_addr;
  logic [NREQ*48-1:0] req_wdata;
  logic [NREQ-1:0]   req_done;
  logic              req_err;
  logic [47:0]       req_rdata;
  logic [14:0]       io_addr;
  logic              io_read;
  logic              io_write;
  logic [47:0]       io_wdata;
  logic [47:0]       io_rdata;
  logic              io_done;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  mesm6_io_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_read  (req_read),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_done  (req_done),
    .req_err   (req_err),
    .req_rdata (req_rdata),
    .io_addr   (io_addr),
    .io_read   (io_read),
    .io_write  (io_write),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .io_done   (io_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic rd, input logic wr,
                         input logic [14:0] addr, input logic [47:0] wdata);
    req_read[idx]            = rd;
    req_write[idx]           = wr;
    req_addr[idx*15 +: 15]   = addr;
    req_wdata[idx*48 +: 48]  = wdata;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " outs"},
             {req_done, req_err, io_read, io_write, busy},
             64'd0);
    check_eq({tag, " data"}, {io_addr, 1'b0, io_wdata != 48'd0, req_rdata != 48'd0}, 64'd0);
  endtask

  // Starts in the IDLE cycle in which the request is already high; returns in the following IDLE.
  // dly: cycles after the strobe at which the device raises io_done (0 = never).
  task automatic transact(input string tag, input int dly, input logic [47:0] dev_data,
                          input logic [NREQ-1:0] exp_vec, input logic exp_wr,
                          input logic [14:0] exp_addr, input logic [47:0] exp_wdata,
                          input logic exp_err, input logic [47:0] exp_rdata, input int exp_lat);
    int  k;
    bit  found;
    bit  extra_strobe;
    io_done  = 1'b0;
    tick();
    check_eq({tag, " io_read"},  io_read,  !exp_wr);
    check_eq({tag, " io_write"}, io_write, exp_wr);
    check_eq({tag, " io_addr"},  io_addr,  exp_addr);
    check_eq({tag, " io_wdata"}, io_wdata, exp_wdata);
    io_rdata     = dev_data;
    k            = 1;
    found        = 1'b0;
    extra_strobe = 1'b0;
    while (!found && k < 40) begin
      tick();
      k++;
      if (req_done != '0) begin
        found = 1'b1;
      end else begin
        extra_strobe = extra_strobe | io_read | io_write;
        io_done = (dly != 0) && (k == 1 + dly);
      end
    end
    $display("txn %s: done=%b err=%0d rdata=%0h latency=%0d", tag, req_done, req_err, req_rdata, k - 1);
    check_eq({tag, " done_seen"}, found, 1'b1);
    check_eq({tag, " req_done"},  req_done, exp_vec);
    check_eq({tag, " req_err"},   req_err, exp_err);
    check_eq({tag, " req_rdata"}, req_rdata, exp_rdata);
    check_eq({tag, " latency"},   k - 1, exp_lat);
    check_eq({tag, " one_strobe"}, extra_strobe, 1'b0);
    check_eq({tag, " addr_hold"}, io_addr, exp_addr);
    io_done = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (exp_vec[j]) begin
        req_read[j]  = 1'b0;
        req_write[j] = 1'b0;
      end
    end
    tick();
    check_eq({tag, " idle_after"}, {busy, req_done}, 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_read  = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    io_rdata  = '0;
    io_done   = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // io_done outside WAIT must not start or finish anything.
    io_done = 1'b1;
    tick();
    tick();
    check_eq("idle_io_done", {busy, req_done}, 64'd0);
    io_done = 1'b0;
    tick();

    set_req(0, 1'b1, 1'b0, 15'o7, 48'd0);
    transact("read0", 1, 48'h123456789ABC, 2'b01, 1'b0, 15'o7, 48'd0,
             1'b0, 48'h123456789ABC, 2);

    // Read and write together: the write is issued, and write completions carry no data.
    set_req(1, 1'b1, 1'b1, 15'o6, 48'hA5);
    transact("write1", 1, 48'hDEAD_BEEF, 2'b10, 1'b1, 15'o6, 48'hA5, 1'b0, 48'd0, 2);

    set_req(0, 1'b1, 1'b0, 15'o10, 48'd0);
    set_req(1, 1'b1, 1'b0, 15'o11, 48'd0);
    for (int i = 0; i < 4; i++) begin
      int w;
      w = i % 2;
      transact($sformatf("rr%0d", i), 1, 48'h1000 + 48'(i), 2'(1 << w), 1'b0,
               15'o10 + 15'(w), 48'd0, 1'b0, 48'h1000 + 48'(i), 2);
      if (i < 3) begin
        set_req(w, 1'b1, 1'b0, 15'o10 + 15'(w), 48'd0);
      end else begin
        req_read = '0;
      end
    end
    tick();

    set_req(0, 1'b1, 1'b0, 15'o20, 48'd0);
    transact("timeout", 0, 48'hFFFF_FFFF, 2'b01, 1'b0, 15'o20, 48'd0, 1'b1, 48'd0, 6);

    set_req(1, 1'b0, 1'b1, 15'o21, 48'h5A5A);
    transact("post_tmo", 1, 48'h1, 2'b10, 1'b1, 15'o21, 48'h5A5A, 1'b0, 48'd0, 2);

    // io_done in the WAIT cycle where the counter equals TIMEOUT still succeeds.
    set_req(0, 1'b1, 1'b0, 15'o22, 48'd0);
    transact("late_done", TIMEOUT + 1, 48'hCAFE, 2'b01, 1'b0, 15'o22, 48'd0, 1'b0, 48'hCAFE, 6);

    // ptr is 1 here; start a read by requester 0 and reset it during WAIT.
    set_req(0, 1'b1, 1'b0, 15'o23, 48'd0);
    tick();
    tick();
    check_eq("pre_reset_busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    req_read = '0;
    tick();
    check_eq("reset_no_done", {busy, req_done}, 64'd0);
    reset = 1'b0;
    tick();

    // Both pending after reset: ptr restarted at 0, so requester 0 wins first.
    set_req(0, 1'b1, 1'b0, 15'o24, 48'd0);
    set_req(1, 1'b1, 1'b0, 15'o25, 48'd0);
    transact("post_rst0", 1, 48'h24, 2'b01, 1'b0, 15'o24, 48'd0, 1'b0, 48'h24, 2);
    transact("post_rst1", 1, 48'h25, 2'b10, 1'b0, 15'o25, 48'd0, 1'b0, 48'h25, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mesm6_io_arbiter.md
# mesm6_io_arbiter

Round-robin arbiter that shares one MESM-6 peripheral register bus between NREQ requesters, for example the CPU I/O path and a debug/DMA port. The bus is the read/write/done port used by the GPIO block and other peripherals. The arbiter serialises transactions, drives a one-cycle read or write strobe to the device, and waits for the device's done. It returns read data and a done pulse to the winning requester, and completes with an error if the device never responds.

## Interface
Parameters:
- NREQ, 2: number of requesters, 2..8
- TIMEOUT, 15: maximum number of WAIT cycles without io_done before an error completion, 1..255

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_read  in  NREQ  per-requester read request, level
- req_write  in  NREQ  per-requester write request, level
- req_addr  in  NREQ×15  per-requester register address
- req_wdata  in  NREQ×48  per-requester write data
- req_done  out  NREQ  one-cycle completion pulse, one-hot
- req_err  out  1  qualifies req_done: the transaction timed out
- req_rdata  out  48  shared read data, valid while any req_done bit is high
- io_addr  out  15  device address
- io_read  out  1  device read strobe
- io_write  out  1  device write strobe
- io_wdata  out  48  device write data
- io_rdata  in  48  device read data
- io_done  in  1  device completion
- busy  out  1  a transaction is in progress (state ≠ IDLE)

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - Requester i is pending if req_read[i] or req_write[i] is high.
  - When any requester is pending, pick the winner g as the first pending index at or after the priority pointer ptr, wrapping modulo NREQ.
  - Latch g, req_addr[g] and req_wdata[g] into io_addr/io_wdata, latch the operation, then go to ISSUE.
  - Write wins if one requester asserts read and write together.
- **ISSUE**: assert io_read or io_write for exactly one cycle, clear the timeout counter, go to WAIT.
- **WAIT**
  - If io_done is high: capture io_rdata into req_rdata (write transactions capture 0) and go to DONE with err=0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, go to DONE with err=1 and req_rdata=0.
  - io_done is ignored in every state except WAIT.
- **DONE**
  - Assert req_done[g] for one cycle and req_err=err.
  - Set ptr to (g+1) mod NREQ, then go to IDLE.
- Requester rule: drop read/write on the clock edge where it samples its req_done high. The arbiter therefore sees the request low in the following IDLE cycle and never re-issues it. A request still high at that point is treated as a new transaction.
- io_addr and io_wdata stay stable from ISSUE through DONE. They hold their last value in IDLE.
- Request inputs are not sampled outside IDLE. Requests that arrive mid-transaction wait.

## Timing
- Reset (asynchronous): state=IDLE, ptr=0, counter=0.
- Reset values of outputs: every output is 0 (req_done, req_err, req_rdata, io_addr, io_read, io_write, io_wdata, busy).
- Reset mid-transaction abandons the device operation. No req_done is issued.
- A request is high in IDLE at cycle 0:
  - io strobe in cycle 1.
  - With a registered-done device such as GPIO, io_done arrives in cycle 2.
  - req_done in cycle 3; the next IDLE is cycle 4.
- Throughput: one transaction per 4 cycles minimum.
- Timeout: req_done arrives TIMEOUT+2 cycles after the strobe cycle.
- io_done high in the same cycle the counter reaches TIMEOUT counts as success.
- Counter width: $clog2(TIMEOUT+1) bits, saturating. It never wraps.
- ptr arithmetic: modulo NREQ. NREQ need not be a power of two.

## Structure
- Shared package mesm6_io_pkg:
  - typedef io_state_t {IDLE, ISSUE, WAIT, DONE}
  - IO_ADDR_W=15, IO_DATA_W=48
- One sub-module, mesm6_rr_pick:
  - Combinational round-robin picker.
  - Inputs: pending[NREQ], ptr.
  - Outputs: valid, winner index.

## Test plan
- Single read: requester 0 reads addr 'o7 while the device returns 48'h123456789ABC → io_read high only in cycle 1, req_done[0] in cycle 3, req_rdata=48'h123456789ABC, req_err=0.
- Write: requester 1 writes 48'hA5 to 'o6 → io_write for one cycle, io_addr='o6, io_wdata=48'hA5, req_done[1] after io_done, req_rdata=0.
- Contention: both requesters hold continuous requests, each dropping and re-raising after its own done → grants alternate 0,1,0,1 starting from 0 after reset. Neither requester is starved.
- Timeout with TIMEOUT=4 and io_done tied low → req_done pulses with req_err=1 and req_rdata=0 exactly 6 cycles after the strobe. The next request proceeds normally.
- Reset asserted during WAIT → all outputs 0 immediately, no req_done. After release, a new request from requester 1 is granted first only if requester 0 is idle, because ptr is 0.
- Late io_done: a device responding 3 cycles after the strobe with TIMEOUT=3 → success, req_err=0.
